// File: rtl/seq_fsm_6s_trace_buf.sv
// seq_fsm_6s_trace_buf: records FSM state transitions with dwell time into a small trace FIFO
module seq_fsm_6s_trace_buf #(
    parameter int DEPTH   = 4,
    parameter int DWELL_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               state,
    input  logic                     out0,
    input  logic                     out1,
    output logic                     trace_val,
    input  logic                     trace_rdy,
    output logic [8+DWELL_W-1:0]     trace_msg,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    localparam int MW = 8 + DWELL_W;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [MW-1:0]      mem [DEPTH];
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [2:0]         last_state;
    logic [DWELL_W-1:0] dwell;
    logic               push;
    logic               pop;
    logic               wr_en;

    // a full FIFO still takes a record when the head leaves in the same cycle
    always_comb begin
        push      = state != last_state;
        trace_val = count != '0;
        pop       = trace_val && trace_rdy;
        wr_en     = push && (count != FULL || pop);
        trace_msg = mem[rd_ptr];
    end

    // transition detection, dwell counting, pointers, occupancy and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            last_state <= '0;
            dwell      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            err        <= 1'b0;
        end else begin
            last_state <= state;
            dwell      <= push ? DWELL_W'(1) : (dwell == '1 ? dwell : dwell + DWELL_W'(1));
            rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
            wr_ptr     <= wr_en ? wr_ptr + AW'(1) : wr_ptr;
            count      <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
            overflow   <= overflow | (push && !wr_en);
            err        <= err | (state[2] & state[1]);
        end
    end

    // record storage; contents past the read pointer are don't-care so no reset is needed
    always_ff @(posedge clk) begin
        if (!reset && wr_en)
            mem[wr_ptr] <= {last_state, state, out1, out0, dwell};
    end
endmodule

// File: tb/tb_seq_fsm_6s_trace_buf.sv
// tb_seq_fsm_6s_trace_buf: random and directed stimulus with a queue-based trace reference
module tb_seq_fsm_6s_trace_buf;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  state = 3'd0;
    logic        out0 = 1'b0;
    logic        out1 = 1'b0;
    logic        trace_rdy = 1'b0;
    logic        trace_val;
    logic [15:0] trace_msg;
    logic [2:0]  count;
    logic        overflow;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    bit go = 1'b0;

    logic [15:0] sb[$];
    int  m_last = 0;
    int  m_dwell = 0;
    bit  m_ovf = 0;
    bit  m_err = 0;

    seq_fsm_6s_trace_buf #(.DEPTH(DEPTH), .DWELL_W(8)) dut (
        .clk(clk), .reset(reset), .state(state), .out0(out0), .out1(out1),
        .trace_val(trace_val), .trace_rdy(trace_rdy), .trace_msg(trace_msg),
        .count(count), .overflow(overflow), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // reference: every sampled transition yields a record unless the queue is already full
    always @(posedge clk) begin
        if (reset) begin
            sb.delete();
            m_last = 0; m_dwell = 0; m_ovf = 0; m_err = 0;
        end else begin
            if (int'(state) != m_last) begin
                if (sb.size() < DEPTH)
                    sb.push_back({3'(m_last), state, out1, out0, 8'(m_dwell)});
                else
                    m_ovf = 1;
                m_last = int'(state);
                m_dwell = 1;
            end else begin
                m_dwell = (m_dwell + 1 > 255) ? 255 : m_dwell + 1;
            end
            if (state >= 3'd6) m_err = 1;
        end
    end

    // monitor: compare outputs mid-cycle, retire the head when the consumer takes it
    always @(negedge clk) begin
        if (go) begin
            check("trace_val", trace_val, sb.size() != 0);
            check("count", count, sb.size());
            check("overflow", overflow, m_ovf);
            check("err", err, m_err);
            if (sb.size() != 0) begin
                check("trace_msg", trace_msg, sb[0]);
                if (trace_rdy && !reset) void'(sb.pop_front());
            end
        end
    end

    task automatic step(input logic [2:0] s, input logic o1, input logic o0, input logic r);
        state = s; out1 = o1; out0 = o0; trace_rdy = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        go = 1'b1;
        reset = 1'b0;
        repeat (3) step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        check("basic msg", trace_msg, 32'h0603);
        check("basic count", count, 1);
        repeat (300) step(2, 0, 0, 1);
        step(0, 0, 0, 0);
        check("sat msg", trace_msg, 32'h40FF);
        check("sat count", count, 1);
        reset = 1'b1;
        step(0, 0, 0, 0);
        reset = 1'b0;
        step(1, 0, 0, 0);
        step(2, 0, 0, 0);
        step(3, 0, 0, 0);
        step(4, 0, 0, 0);
        check("full count", count, 4);
        step(5, 0, 0, 1);
        check("pushpop count", count, 4);
        check("pushpop ovf", overflow, 0);
        step(0, 0, 0, 0);
        check("drop count", count, 4);
        check("drop ovf", overflow, 1);
        repeat (6) step(0, 0, 0, 1);
        check("drained", count, 0);
        step(6, 0, 1, 0);
        check("err set", err, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("err sticky", err, 1);
        step(1, 0, 0, 0);
        step(2, 0, 0, 0);
        repeat (4) step(2, 0, 0, 0);
        reset = 1'b1;
        step(0, 0, 0, 0);
        check("rst val", trace_val, 0);
        check("rst count", count, 0);
        check("rst ovf", overflow, 0);
        check("rst err", err, 0);
        reset = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("post-rst msg", trace_msg, 32'h0402);
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(199) == 0);
            step(($urandom_range(3) == 0) ? 3'($urandom_range(7)) : state,
                 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(2) != 0);
        end
        reset = 1'b0;
        repeat (2) step(state, 0, 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
